// File: rtl/alu_result_collector.sv
// alu_result_collector
//   Downstream stage of the ALU core. Captures each signed result strobed by
//   c_en into a show-ahead FIFO, presents the head over valid/ready, and keeps
//   a saturating running sum, a wrapping sequence tag and drop statistics.
//   Optional feature macro: ALU_RES_PARITY_EN adds out_par, the even parity of
//   {out_data, out_tag}, computed and stored per entry at push time.
module alu_result_collector #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8,
    parameter int ACC_W  = 10,
    parameter int TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       c_en,
    input  logic signed [DATA_W-1:0]   c,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_data,
    output logic        [TAG_W-1:0]    out_tag,
    output logic signed [ACC_W-1:0]    acc,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       drop,
    output logic        [7:0]          drop_cnt
`ifdef ALU_RES_PARITY_EN
    ,
    output logic                       out_par
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_ONE      = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_NEARFULL = LVL_W'(DEPTH - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic               drop_q, drop_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [TAG_W-1:0]   tag_mem  [DEPTH];
`ifdef ALU_RES_PARITY_EN
    logic               par_mem  [DEPTH];
`endif

    logic               push, pop, drop_now;
    logic [ACC_W:0]     acc_sum;

    // Handshake decode: clr suppresses both sides; a full FIFO still takes a
    // push when the head leaves in the same cycle.
    always_comb begin
        pop      = out_valid && out_ready && !clr;
        push     = c_en && !clr && (!full || pop);
        drop_now = c_en && !clr && full && !pop;
    end

    // Occupancy FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Occupancy FSM: next state from push/pop and current level.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY:   if (push) state_d = ST_PARTIAL;
                ST_PARTIAL: begin
                    if (push && !pop && level_q == LVL_NEARFULL)
                        state_d = ST_FULL;
                    else if (pop && !push && level_q == LVL_ONE)
                        state_d = ST_EMPTY;
                end
                ST_FULL:    if (pop && !push) state_d = ST_PARTIAL;
                default:    state_d = ST_EMPTY;
            endcase
        end
    end

    // Occupancy FSM: decoded status outputs.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        full      = (state_q == ST_FULL);
    end

    // Pointer, level and tag next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        tag_d    = tag_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            tag_d    = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                tag_d    = tag_q + TAG_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Saturating accumulate of accepted results; one guard bit detects overflow.
    always_comb begin
        acc_sum = {acc_q[ACC_W-1], acc_q}
                + {{(ACC_W+1-DATA_W){c[DATA_W-1]}}, c};
        acc_d   = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (push) begin
            if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
                acc_d = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
            else
                acc_d = acc_sum[ACC_W-1:0];
        end
    end

    // Drop accounting: sticky flag plus a count that sticks at 255.
    always_comb begin
        drop_d     = drop_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            drop_d     = 1'b0;
            drop_cnt_d = '0;
        end else if (drop_now) begin
            drop_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Control and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tag_q      <= '0;
            acc_q      <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tag_q      <= tag_d;
            acc_q      <= acc_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage; contents are only observed through a valid head, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= c;
            tag_mem[wr_ptr_q]  <= tag_q;
`ifdef ALU_RES_PARITY_EN
            par_mem[wr_ptr_q]  <= ^{c, tag_q};
`endif
        end
    end

    // Head presentation: forced to zero while empty so reset shows clean zeros.
    always_comb begin
        out_data = out_valid ? $signed(data_mem[rd_ptr_q]) : '0;
        out_tag  = out_valid ? tag_mem[rd_ptr_q] : '0;
`ifdef ALU_RES_PARITY_EN
        out_par  = out_valid ? par_mem[rd_ptr_q] : 1'b0;
`endif
    end

    // Status outputs straight from registers.
    always_comb begin
        acc      = acc_q;
        level    = level_q;
        drop     = drop_q;
        drop_cnt = drop_cnt_q;
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based reference model of the collector.
module tb_alu_result_collector;

    localparam int DATA_W = 6;
    localparam int DEPTH  = 8;
    localparam int ACC_W  = 10;
    localparam int TAG_W  = 4;
    localparam int ACC_HI = (1 << (ACC_W-1)) - 1;
    localparam int ACC_LO = -(1 << (ACC_W-1));

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     clr = 1'b0;
    logic                     c_en = 1'b0;
    logic signed [DATA_W-1:0] c = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]         out_tag;
    logic signed [ACC_W-1:0]  acc;
    logic [$clog2(DEPTH):0]   level;
    logic                     full;
    logic                     drop;
    logic [7:0]               drop_cnt;
`ifdef ALU_RES_PARITY_EN
    logic                     out_par;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_data[$];
    int m_tag[$];
    int m_acc, m_tagc, m_drop, m_dcnt;

    alu_result_collector #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .c_en(c_en), .c(c),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .acc(acc), .level(level), .full(full),
        .drop(drop), .drop_cnt(drop_cnt)
`ifdef ALU_RES_PARITY_EN
        , .out_par(out_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_data.delete();
        m_tag.delete();
        m_acc = 0; m_tagc = 0; m_drop = 0; m_dcnt = 0;
    endfunction

    // One clock edge of behaviour, from the inputs that were held across it.
    function automatic void model_edge();
        bit pop, fl;
        if (clr) begin
            model_reset();
            return;
        end
        pop = (m_data.size() > 0) && out_ready;
        fl  = (m_data.size() == DEPTH);
        if (pop) begin
            void'(m_data.pop_front());
            void'(m_tag.pop_front());
        end
        if (c_en) begin
            if (fl && !pop) begin
                m_drop = 1;
                if (m_dcnt < 255) m_dcnt++;
            end else begin
                m_data.push_back(int'(c));
                m_tag.push_back(m_tagc);
                m_tagc = (m_tagc + 1) % (1 << TAG_W);
                m_acc  = m_acc + int'(c);
                if (m_acc > ACC_HI) m_acc = ACC_HI;
                if (m_acc < ACC_LO) m_acc = ACC_LO;
            end
        end
    endfunction

    task automatic check_all();
        int n;
        n = m_data.size();
        chk("out_valid", out_valid, n > 0);
        chk("level", level, n);
        chk("full", full, n == DEPTH);
        chk("acc", acc, m_acc);
        chk("drop", drop, m_drop);
        chk("drop_cnt", drop_cnt, m_dcnt);
        if (n > 0) begin
            chk("out_data", out_data, m_data[0]);
            chk("out_tag", out_tag, m_tag[0]);
`ifdef ALU_RES_PARITY_EN
            chk("out_par", out_par,
                ^{DATA_W'(m_data[0]), TAG_W'(m_tag[0])});
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic ce, input int cv, input logic rdy,
                         input logic cl);
        c_en = ce; c = DATA_W'(cv); out_ready = rdy; clr = cl;
        step();
        c_en = 1'b0; out_ready = 1'b0; clr = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        c_en = 1'b0; out_ready = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        rst_n = 1'b1;

        // T1: single push, show-ahead latency of one
        drive(1, 5, 0, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 5);
        chk("t1_tag", out_tag, 0);
        chk("t1_level", level, 1);
        chk("t1_acc", acc, 5);

        // T2: overfill by one, then drain in order
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            drive(1, i, 0, 0);
            if (i == 8) chk("t2_full8", full, 1);
        end
        chk("t2_drop", drop, 1);
        chk("t2_dcnt", drop_cnt, 1);
        chk("t2_acc", acc, 36);
        for (int i = 0; i < 8; i++) begin
            chk("t2_pop_tag", out_tag, i);
            chk("t2_pop_data", out_data, i + 1);
            drive(0, 0, 1, 0);
        end
        chk("t2_empty", out_valid, 0);

        // T3: push into a full FIFO while the head leaves
        do_reset();
        for (int i = 1; i <= 8; i++) drive(1, i, 0, 0);
        drive(1, -3, 1, 0);
        chk("t3_level", level, 8);
        chk("t3_dcnt", drop_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                chk("t3_tail_tag", out_tag, 8);
                chk("t3_tail_data", out_data, -3);
            end
            drive(0, 0, 1, 0);
        end

        // T4: positive saturation, then back off with the most negative value
        do_reset();
        for (int i = 0; i < 35; i++) drive(1, 31, i % 2, 0);
        chk("t4_sat", acc, 511);
        drive(1, -32, 1, 0);
        chk("t4_after", acc, 479);

        // T5: clr wins over a simultaneous push
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, i + 1, 0, 0);
        chk("t5_level3", level, 3);
        drive(1, 7, 0, 1);
        chk("t5_level", level, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_acc", acc, 0);
        chk("t5_drop", drop, 0);
        drive(1, 2, 0, 0);
        chk("t5_tag", out_tag, 0);

`ifdef ALU_RES_PARITY_EN
        // parity of c=3 with tag 1
        do_reset();
        drive(1, 2, 0, 0);
        drive(1, 3, 1, 0);
        chk("par_c3_t1", out_par, 1);
`endif

        // Randomized traffic with occasional clr
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 63) - 32,
                  ($urandom_range(0, 2) == 0) || (i > 1500 && $urandom_range(0, 1) == 1),
                  ($urandom_range(0, 63) == 0));
        end

        // T6: asynchronous reset in the middle of a cycle
        for (int i = 0; i < 4; i++) drive(1, 9, 0, 0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("t6_valid", out_valid, 0);
        chk("t6_level", level, 0);
        chk("t6_acc", acc, 0);
        chk("t6_dcnt", drop_cnt, 0);
        #2;
        rst_n = 1'b1;
        drive(1, 4, 0, 0);
        chk("t6_tag", out_tag, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
